// File: rtl/image_frame_loader.sv
// -----------------------------------------------------------------------------
// image_frame_loader
//
// Captures a binary image of IMG_H x IMG_W pixels that arrives as BUS_W-pixel
// beats on a valid/ready stream. Beats are assembled in a capture buffer. When
// the last beat of a frame lands, the whole buffer, including that beat, is
// copied in one step to a held output register for the inference core. The
// next frame can then be captured while the consumer still works on the
// current one.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     beat present on in_data
//   in_ready     block accepts a beat this cycle (combinational from frame_ack)
//   in_data      BUS_W pixels; bit k = column b*BUS_W+k on beat b of a row
//   in_sof       marks the beat as pixel (0,0) of a new frame
//   frame_data   held frame; pixel (r,c) at bit r*IMG_W+c
//   frame_valid  frame_data holds a complete frame that is not yet consumed
//   frame_ack    consumer releases frame_data
//   sync_err     one-cycle pulse after a framing violation
//   frame_count  completed frames, wraps 255 -> 0
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a beat with in_sof; other beats are dropped and flagged
// FILL  | capturing a frame; in_sof restarts it, the last position completes it
// -----------------------------------------------------------------------------
module image_frame_loader #(
    parameter int IMG_W = 14,
    parameter int IMG_H = 14,
    parameter int BUS_W = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BUS_W-1:0]       in_data,
    input  logic                   in_sof,
    output logic [IMG_W*IMG_H-1:0] frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ack,
    output logic                   sync_err,
    output logic [7:0]             frame_count
);

    localparam int BPR    = IMG_W / BUS_W;
    localparam int PIX    = IMG_W * IMG_H;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BEAT_W = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPR - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [ROW_W-1:0]   row;
    logic [BEAT_W-1:0]  beat;
    logic [PIX-1:0]     cap;

    // FSM output decode
    logic               at_last;
    logic               accept;
    logic               do_write;
    logic               restart;
    logic               err_set;
    logic               complete;

    // Write position and the position that follows it
    logic [ROW_W-1:0]   wr_row;
    logic [BEAT_W-1:0]  wr_beat;
    logic [ROW_W-1:0]   row_nxt;
    logic [BEAT_W-1:0]  beat_nxt;
    logic [PIX-1:0]     cap_nxt;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && in_sof) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (complete) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / control decode
    // -------------------------------------------------------------------------
    always_comb begin
        at_last  = (state == S_FILL) && (row == LAST_ROW) && (beat == LAST_BEAT);
        // Stall only the completing beat, and only while the held frame is
        // still owned by the consumer. An ack in the same cycle frees the
        // register, so the completion may go ahead on that edge.
        in_ready = !(at_last && frame_valid && !frame_ack);
        accept   = in_valid && in_ready;
        do_write = 1'b0;
        restart  = 1'b0;
        err_set  = 1'b0;
        complete = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        do_write = 1'b1;
                        restart  = 1'b1;
                    end else begin
                        err_set  = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    do_write = 1'b1;
                    if (in_sof) begin
                        restart  = 1'b1;
                        err_set  = 1'b1;
                    end else if (at_last) begin
                        complete = 1'b1;
                    end
                end
            end
            default: begin
                do_write = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Capture position and buffer update
    // -------------------------------------------------------------------------
    always_comb begin
        wr_row  = restart ? '0 : row;
        wr_beat = restart ? '0 : beat;

        // The last position wraps to (0,0), which leaves the counters ready
        // for the next frame without a separate clear.
        if (wr_beat == LAST_BEAT) begin
            beat_nxt = '0;
            row_nxt  = (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
        end else begin
            beat_nxt = wr_beat + 1'b1;
            row_nxt  = wr_row;
        end

        cap_nxt = cap;
        for (int r = 0; r < IMG_H; r++) begin
            for (int b = 0; b < BPR; b++) begin
                if (do_write && (wr_row == ROW_W'(r)) && (wr_beat == BEAT_W'(b))) begin
                    cap_nxt[(r*BPR + b)*BUS_W +: BUS_W] = in_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row         <= '0;
            beat        <= '0;
            cap         <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_count <= 8'd0;
            sync_err    <= 1'b0;
        end else begin
            sync_err <= err_set;
            if (do_write) begin
                row  <= row_nxt;
                beat <= beat_nxt;
                cap  <= cap_nxt;
            end
            // Completion wins over ack: the freshly copied frame is unconsumed.
            if (complete) begin
                frame_data  <= cap_nxt;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
module tb_image_frame_loader;

    logic         clk;
    logic         reset_n;

    logic         in_valid;
    logic         in_ready;
    logic [6:0]   in_data;
    logic         in_sof;
    logic [195:0] frame_data;
    logic         frame_valid;
    logic         frame_ack;
    logic         sync_err;
    logic [7:0]   frame_count;

    logic         v_in_valid;
    logic         v_in_ready;
    logic [3:0]   v_in_data;
    logic         v_in_sof;
    logic [31:0]  v_frame_data;
    logic         v_frame_valid;
    logic         v_frame_ack;
    logic         v_sync_err;
    logic [7:0]   v_frame_count;

    int total;
    int bad;
    int err_cnt;

    image_frame_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .sync_err    (sync_err),
        .frame_count (frame_count)
    );

    image_frame_loader #(.IMG_W(8), .IMG_H(4), .BUS_W(4)) dut_v (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (v_in_valid),
        .in_ready    (v_in_ready),
        .in_data     (v_in_data),
        .in_sof      (v_in_sof),
        .frame_data  (v_frame_data),
        .frame_valid (v_frame_valid),
        .frame_ack   (v_frame_ack),
        .sync_err    (v_sync_err),
        .frame_count (v_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of sync_err pulses on the default instance
    initial err_cnt = 0;
    always @(negedge clk) if (sync_err === 1'b1) err_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] pat_beat(input int pat, input int i);
        case (pat)
            0:       return (i % 2 == 0) ? 7'h55 : 7'h2A;
            1:       return 7'(i * 5 + 3);
            2:       return 7'(i ^ 'h4C);
            default: return 7'(~(i * 9));
        endcase
    endfunction

    // Pixel (r,c) at bit r*14+c; beat b of row r carries columns b*7..b*7+6
    function automatic logic [195:0] pat_frame(input int pat);
        logic [195:0] f;
        logic [6:0]   bv;
        f = '0;
        for (int r = 0; r < 14; r++) begin
            for (int b = 0; b < 2; b++) begin
                bv = pat_beat(pat, r * 2 + b);
                for (int k = 0; k < 7; k++) f[r * 14 + b * 7 + k] = bv[k];
            end
        end
        return f;
    endfunction

    // Called at negedge+1; leaves at the following negedge+1
    task automatic beat(input logic [6:0] d, input logic sof);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        @(negedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        frame_ack   = 1'b0;
        v_in_valid  = 1'b0;
        v_in_sof    = 1'b0;
        v_frame_ack = 1'b0;
        reset_n     = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_data = 0; in_sof = 0; frame_ack = 0;
        v_in_valid = 0; v_in_data = 0; v_in_sof = 0; v_frame_ack = 0;
        reset_n = 1'b0;
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", frame_valid); end
        total++; if (frame_data !== 196'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", frame_data); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL reset_sync_err got=%0b exp=0", sync_err); end
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_default();
        int e0;
        do_reset();
        e0 = err_cnt;
        for (int i = 0; i < 27; i++) beat(pat_beat(0, i), i == 0);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL default_early_valid got=%0b exp=0", frame_valid); end
        beat(7'h2A, 1'b0);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL default_valid got=%0b exp=1", frame_valid); end
        total++; if (frame_data !== {14{14'h1555}}) begin bad++; $display("FAIL default_data got=%0h exp=%0h", frame_data, {14{14'h1555}}); end
        total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL default_count got=%0d exp=1", frame_count); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL default_sync_err got=%0d exp=0", err_cnt - e0); end
        frame_ack = 1'b1;
        @(negedge clk); #1;
        frame_ack = 1'b0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL ack_clear got=%0b exp=0", frame_valid); end
        total++; if (frame_data !== {14{14'h1555}}) begin bad++; $display("FAIL ack_hold_data got=%0h exp=%0h", frame_data, {14{14'h1555}}); end
        // ack with nothing held must be harmless
        frame_ack = 1'b1;
        @(negedge clk); #1;
        frame_ack = 1'b0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL idle_ack got=%0b exp=0", frame_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 28; i++) beat(pat_beat(1, i), i == 0);
        total++; if (frame_data !== pat_frame(1)) begin bad++; $display("FAIL bp_frame1 got=%0h exp=%0h", frame_data, pat_frame(1)); end
        for (int i = 0; i < 27; i++) beat(pat_beat(3, i), i == 0);
        in_valid = 1'b1; in_data = pat_beat(3, 27); in_sof = 1'b0; frame_ack = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%0b exp=0", in_ready); end
        @(negedge clk); #1;
        total++; if (frame_data !== pat_frame(1)) begin bad++; $display("FAIL bp_stall_data got=%0h exp=%0h", frame_data, pat_frame(1)); end
        total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL bp_stall_count got=%0d exp=1", frame_count); end
        frame_ack = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ack_ready got=%0b exp=1", in_ready); end
        @(negedge clk); #1;
        in_valid = 1'b0; frame_ack = 1'b0;
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%0b exp=1", frame_valid); end
        total++; if (frame_data !== pat_frame(3)) begin bad++; $display("FAIL bp_frame2 got=%0h exp=%0h", frame_data, pat_frame(3)); end
        total++; if (frame_count !== 8'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", frame_count); end
    endtask

    // Follows test_backpressure, so a held frame is present when reset hits
    task automatic test_midstream_reset();
        int e0;
        for (int i = 0; i < 6; i++) beat(pat_beat(1, i), i == 0);
        reset_n = 1'b0;
        #1;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%0b exp=0", frame_valid); end
        total++; if (frame_data !== 196'd0) begin bad++; $display("FAIL mid_reset_data got=%0h exp=0", frame_data); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", frame_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%0b exp=1", in_ready); end
        @(negedge clk); #1;
        reset_n = 1'b1;
        e0 = err_cnt;
        for (int i = 6; i < 28; i++) beat(pat_beat(1, i), 1'b0);
        @(negedge clk); #1;
        total++; if (err_cnt - e0 !== 22) begin bad++; $display("FAIL mid_reset_sync_err got=%0d exp=22", err_cnt - e0); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_no_frame got=%0b exp=0", frame_valid); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL mid_reset_no_count got=%0d exp=0", frame_count); end
    endtask

    task automatic test_resync();
        int e0;
        do_reset();
        e0 = err_cnt;
        for (int i = 0; i < 10; i++) beat(pat_beat(2, i), i == 0);
        beat(pat_beat(4, 0), 1'b1);
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL resync_pulse got=%0b exp=1", sync_err); end
        for (int i = 1; i < 27; i++) beat(pat_beat(4, i), 1'b0);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL resync_early got=%0b exp=0", frame_valid); end
        beat(pat_beat(4, 27), 1'b0);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL resync_valid got=%0b exp=1", frame_valid); end
        total++; if (frame_data !== pat_frame(4)) begin bad++; $display("FAIL resync_data got=%0h exp=%0h", frame_data, pat_frame(4)); end
        total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL resync_count got=%0d exp=1", frame_count); end
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL resync_err_cnt got=%0d exp=1", err_cnt - e0); end
    endtask

    task automatic test_stray();
        int e0;
        do_reset();
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 7'(i + 1); in_sof = 1'b0;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stray_ready got=%0b exp=1", in_ready); end
            @(negedge clk); #1;
            total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL stray_pulse got=%0b exp=1", sync_err); end
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL stray_pulse_end got=%0b exp=0", sync_err); end
        total++; if (err_cnt - e0 !== 3) begin bad++; $display("FAIL stray_err_cnt got=%0d exp=3", err_cnt - e0); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL stray_count got=%0d exp=0", frame_count); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL stray_valid got=%0b exp=0", frame_valid); end
    endtask

    // 8x4 image, 4-pixel beats: beat b lands at bits 4b..4b+3
    task automatic test_variant();
        logic [31:0] buf_m;
        logic [31:0] data_m;
        logic        valid_m;
        logic [7:0]  cnt_m;
        logic [3:0]  d;
        logic        exp_rdy;
        logic        done;
        int          tries;
        do_reset();
        buf_m = '0; data_m = '0; valid_m = 1'b0; cnt_m = 8'd0;
        for (int f = 0; f < 256; f++) begin
            for (int b = 0; b < 8; b++) begin
                d = 4'($urandom);
                done = 1'b0;
                tries = 0;
                while (!done) begin
                    v_in_valid  = 1'b1;
                    v_in_data   = d;
                    v_in_sof    = (b == 0);
                    v_frame_ack = ($urandom_range(0, 2) == 0);
                    #1;
                    exp_rdy = !(b == 7 && valid_m && !v_frame_ack);
                    total++; if (v_in_ready !== exp_rdy) begin bad++; $display("FAIL var_ready f=%0d b=%0d got=%0b exp=%0b", f, b, v_in_ready, exp_rdy); end
                    @(posedge clk);
                    if (exp_rdy) begin
                        buf_m[b * 4 +: 4] = d;
                        done = 1'b1;
                    end
                    if (exp_rdy && b == 7) begin
                        data_m  = buf_m;
                        valid_m = 1'b1;
                        cnt_m   = cnt_m + 8'd1;
                    end else if (v_frame_ack) begin
                        valid_m = 1'b0;
                    end
                    @(negedge clk); #1;
                    total++; if (v_frame_valid !== valid_m) begin bad++; $display("FAIL var_valid f=%0d got=%0b exp=%0b", f, v_frame_valid, valid_m); end
                    total++; if (v_frame_data !== data_m) begin bad++; $display("FAIL var_data f=%0d got=%0h exp=%0h", f, v_frame_data, data_m); end
                    total++; if (v_frame_count !== cnt_m) begin bad++; $display("FAIL var_count f=%0d got=%0d exp=%0d", f, v_frame_count, cnt_m); end
                    total++; if (v_sync_err !== 1'b0) begin bad++; $display("FAIL var_sync_err f=%0d got=%0b exp=0", f, v_sync_err); end
                    tries++;
                    if (!done && tries > 64) begin
                        total++; bad++;
                        $display("FAIL var_stall_timeout f=%0d got=stalled exp=accepted", f);
                        done = 1'b1;
                    end
                end
            end
        end
        v_in_valid = 1'b0; v_in_sof = 1'b0; v_frame_ack = 1'b0;
        total++; if (v_frame_count !== 8'd0) begin bad++; $display("FAIL var_wrap got=%0d exp=0", v_frame_count); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_default();
        test_backpressure();
        test_midstream_reset();
        test_resync();
        test_stray();
        test_variant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_frame_loader.md
# image_frame_loader

Parametrised frame capture block for the MNIST accelerator input path. It accepts a binary image of IMG_H rows by IMG_W columns as a stream of BUS_W-pixel beats over a valid/ready handshake, with a start-of-frame marker for resynchronisation. The frame is assembled in an internal capture buffer and transferred atomically to a held output register for the inference core. Capture of the next frame overlaps with the consumer's use of the current frame.

## Interface
Parameters:
- IMG_W, 14, image width in pixels; must be a multiple of BUS_W
- IMG_H, 14, image height in rows
- BUS_W, 7, pixels (1 bit each) per input beat
- Derived: BPR = IMG_W/BUS_W beats per row; total beats BPR*IMG_H must be ≥ 2

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present on in_data
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  BUS_W  pixels; bit k = column b*BUS_W+k on beat b of a row
- in_sof  in  1  qualifies the beat as pixel (0,0) of a new frame
- frame_data  out  IMG_W*IMG_H  pixel (r,c) at bit r*IMG_W+c
- frame_valid  out  1  frame_data holds a complete, unconsumed frame
- frame_ack  in  1  consumer releases frame_data
- sync_err  out  1  one-cycle pulse on a framing violation
- frame_count  out  8  completed frames, wraps 255→0

## Operation
- Beat accepted ⇔ in_valid && in_ready at a rising edge.
- Row counter 0..IMG_H-1 and beat counter 0..BPR-1 track the capture position.
- State IDLE, waiting for SOF:
  - An accepted beat with in_sof=1 is written at row 0, beat 0. Position advances. Next state is FILL.
  - An accepted beat with in_sof=0 is discarded and sync_err pulses. State stays IDLE.
- State FILL:
  - An accepted beat with in_sof=0 is written at the current position, which then advances. The beat wraps to 0 and increments the row at beat BPR-1.
  - An accepted beat with in_sof=1 restarts capture. The partial frame is abandoned, the beat is written as row 0, beat 0, and sync_err pulses.
  - On the last position (row IMG_H-1, beat BPR-1) without sof:
    - The capture buffer, including this beat, is copied to frame_data.
    - frame_valid is set to 1 and frame_count increments.
    - State returns to IDLE.
- in_ready = 0 only when in FILL at the last position while frame_valid=1 and frame_ack=0. Otherwise in_ready = 1. This is a combinational path from frame_ack.
- frame_ack while frame_valid=1 clears frame_valid on the next edge. frame_ack while frame_valid=0 is ignored.
- A completion and an ack on the same edge leave frame_valid=1 with the new frame_data.
- frame_data changes only on completion. It holds its value otherwise, including after ack.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - State IDLE, counters 0, capture buffer 0.
  - frame_data 0, frame_valid 0, sync_err 0, frame_count 0.
  - in_ready 1, effective as soon as reset_n=1.
- Reset asserted mid-frame discards the partial frame and any held frame immediately. The first beat after release must carry in_sof.
- Latency: the last beat is accepted at edge N. frame_valid=1 and the new frame_data/frame_count are visible from edge N onward, i.e. in the following cycle.
- Minimum frame period is BPR*IMG_H cycles, with back-to-back frames at full rate when the consumer acks in time.
- sync_err is high for exactly the one cycle after the offending edge.
- Idle cycles (in_valid=0) hold position. There is no timeout.

## Test plan
- Reset: apply reset_n=0 mid-stream → all outputs at reset values. The next beat without sof raises sync_err and no frame is produced.
- Default 14×14: send 28 continuous beats, where row r carries 7'h55 and 7'h2A, with sof on beat 0 → frame_valid=1 in the cycle after beat 28, frame_data matches the bit-map, frame_count=1, sync_err never pulses.
- Backpressure: send frame 1 and do not ack, then stream frame 2 → in_ready=0 on frame 2's last beat. Assert frame_ack → the last beat is accepted on that edge, frame_valid stays 1, frame_data equals frame 2, frame_count=2.
- Resync: assert in_sof at beat 10 of a frame → sync_err pulses once. The frame completes 27 beats later with data from the restarted frame only.
- Stray beats: send 3 beats without sof in IDLE → 3 sync_err pulses, in_ready stays 1, frame_count unchanged.
- Parameter variant IMG_W=8, IMG_H=4, BUS_W=4 → 8 beats per frame. 256 frames with random acks → frame_count wraps to 0 and data matches the model on every frame.
